pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 181 ++++++++++++++++++
 tb/tb_pll_reset_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL lock filter and system reset sequencer, clocked from the PLL reference.
// Optional lock-timeout watchdog enabled by defining PLL_SEQ_WATCHDOG_EN.
module pll_reset_seq #(
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES     = 65536,
  parameter int PLL_RESET_CYCLES   = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       sw_reset_req,
  output logic       pll_resetb,
  output logic       rst_out_n,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count,
  output logic [1:0] state
);

  localparam int FW = (LOCK_FILTER_CYCLES > 1) ?
    $clog2(LOCK_FILTER_CYCLES) : 1;
  localparam int HW = (RESET_HOLD_CYCLES > 1) ?
    $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [FW-1:0] FMAX = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(RESET_HOLD_CYCLES - 1);

  if (LOCK_FILTER_CYCLES < 1 || RESET_HOLD_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || PLL_RESET_CYCLES < 1) begin : g_bad
    $error("pll_reset_seq: cycle parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t cur;
  state_t nxt;

  logic          rst_meta;
  logic          rst_n_int;
  logic          lock_meta;
  logic          lock_s;
  logic          pll_ok;
  logic          loss_inc;
  logic [FW-1:0] filt_cnt;
  logic [FW-1:0] filt_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;

  // Assert asynchronously, release on the clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta  <= 1'b0;
      rst_n_int <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_n_int <= rst_meta;
    end
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    nxt      = cur;
    filt_nxt = filt_cnt;
    hold_nxt = hold_cnt;
    loss_inc = 1'b0;
    unique case (cur)
      WAIT_LOCK: begin
        filt_nxt = '0;
        if (lock_s && pll_ok) nxt = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          nxt = WAIT_LOCK;
        end else if (filt_cnt == FMAX) begin
          nxt      = HOLD;
          hold_nxt = '0;
        end else begin
          filt_nxt = filt_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          nxt = WAIT_LOCK;
        end else if (hold_cnt == HMAX) begin
          nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          nxt      = WAIT_LOCK;
          loss_inc = 1'b1;
        end else if (sw_reset_req) begin
          nxt      = HOLD;
          hold_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cur             <= WAIT_LOCK;
      filt_cnt        <= '0;
      hold_cnt        <= '0;
      rst_out_n       <= 1'b0;
      ready           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      cur       <= nxt;
      filt_cnt  <= filt_nxt;
      hold_cnt  <= hold_nxt;
      rst_out_n <= (nxt == RUN);
      ready     <= (nxt == RUN);
      if (loss_inc && lock_loss_count != 8'hff)
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state = cur;

`ifdef PLL_SEQ_WATCHDOG_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PW = (PLL_RESET_CYCLES > 1) ?
    $clog2(PLL_RESET_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PMAX = PW'(PLL_RESET_CYCLES - 1);

  logic [TW-1:0] wait_cnt;
  logic [PW-1:0] pulse_cnt;

  // Lock is ignored while the PLL is being held in reset.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wait_cnt      <= '0;
      pulse_cnt     <= '0;
      pll_resetb    <= 1'b1;
      timeout_count <= '0;
    end else if (!pll_resetb) begin
      if (pulse_cnt == PMAX) begin
        pll_resetb <= 1'b1;
        pulse_cnt  <= '0;
      end else begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end
    end else if (cur != WAIT_LOCK || nxt != WAIT_LOCK) begin
      wait_cnt <= '0;
    end else if (wait_cnt == TMAX) begin
      wait_cnt   <= '0;
      pll_resetb <= 1'b0;
      if (timeout_count != 8'hff)
        timeout_count <= timeout_count + 8'd1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign pll_ok = pll_resetb;
`else
  assign pll_resetb    = 1'b1;
  assign timeout_count = '0;
  assign pll_ok        = 1'b1;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed timing steps plus random lock/sw traffic
// checked every cycle against a phase-level reference model.
module tb_pll_reset_seq;

  localparam int NF = 8;
  localparam int NH = 4;
  localparam int NT = 32;
  localparam int NP = 4;
`ifdef PLL_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_resetb;
  logic       rst_out_n;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [7:0] timeout_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  pll_reset_seq #(
    .LOCK_FILTER_CYCLES(NF),
    .RESET_HOLD_CYCLES (NH),
    .TIMEOUT_CYCLES    (NT),
    .PLL_RESET_CYCLES  (NP)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .locked         (locked),
    .sw_reset_req   (sw_reset_req),
    .pll_resetb     (pll_resetb),
    .rst_out_n      (rst_out_n),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .timeout_count  (timeout_count),
    .state          (state)
  );

  always #5 clock = ~clock;

  // Reference model: phase, cycles spent in phase, and event counts.
  int m_st, m_run, m_hold, m_wait, m_pulse, m_loss, m_tmo, m_skip;
  bit m_s1, m_s2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_run = 0; m_hold = 0; m_wait = 0;
    m_pulse = 0; m_loss = 0; m_tmo = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
    m_skip = 1000000;
  endtask

  task automatic model_step();
    bit ls;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = locked;
    case (m_st)
      0: begin
        if (m_pulse > 0) begin
          m_pulse--;
        end else if (ls) begin
          m_st = 1; m_run = 0; m_wait = 0;
        end else if (WD) begin
          m_wait++;
          if (m_wait == NT) begin
            m_wait = 0;
            m_pulse = NP;
            if (m_tmo < 255) m_tmo++;
          end
        end
      end
      1: begin
        if (!ls) m_st = 0;
        else begin
          m_run++;
          if (m_run == NF) begin m_st = 2; m_hold = NH; end
        end
      end
      2: begin
        if (!ls) m_st = 0;
        else begin
          m_hold--;
          if (m_hold == 0) m_st = 3;
        end
      end
      default: begin
        if (!ls) begin
          m_st = 0;
          if (m_loss < 255) m_loss++;
        end else if (sw_reset_req) begin
          m_st = 2; m_hold = NH;
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("state", state, m_st);
    chk("rst_out_n", rst_out_n, m_st == 3);
    chk("ready", ready, m_st == 3);
    chk("pll_resetb", pll_resetb, m_pulse == 0);
    chk("lock_loss_count", lock_loss_count, m_loss);
    chk("timeout_count", timeout_count, m_tmo);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    locked = 1'b0;
    sw_reset_req = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    m_skip = 2;
    repeat (2) cycle();
  endtask

  task automatic relock(input string tag);
    int n;
    locked = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (state != 2'd3 && n < 60);
    chk(tag, n, 15);
  endtask

  initial begin
    int n, lowc;
    do_reset();

    // Lock rise to FILTER, HOLD and RUN.
    locked = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (state != 2'd1 && n < 60);
    chk("filter_entry", n, 3);
    do begin cycle(); n++; end while (state != 2'd2 && n < 60);
    chk("hold_entry", n, 11);
    do begin cycle(); n++; end while (state != 2'd3 && n < 60);
    chk("run_entry", n, 15);
    chk("run_rst_out_n", rst_out_n, 1);

    // Lock loss in RUN, then relock.
    locked = 1'b0;
    repeat (3) cycle();
    chk("loss_rst_out_n", rst_out_n, 0);
    chk("loss_count_1", lock_loss_count, 1);
    relock("relock_run");

    // Short lock with a one-cycle glitch restarts the filter.
    locked = 1'b0;
    repeat (10) cycle();
    locked = 1'b1;
    repeat (5) cycle();
    locked = 1'b0;
    cycle();
    relock("glitch_run");

    // Software reset pulse in RUN.
    lowc = 0;
    sw_reset_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      sw_reset_req = 1'b0;
      if (!rst_out_n) lowc++;
    end
    chk("sw_hold_len", lowc, NH);
    chk("sw_loss_same", lock_loss_count, 2);

    // Software request coincident with synchronized lock drop.
    locked = 1'b0;
    cycle();
    cycle();
    sw_reset_req = 1'b1;
    cycle();
    sw_reset_req = 1'b0;
    chk("coinc_state", state, 0);
    chk("coinc_loss", lock_loss_count, 3);
    relock("coinc_relock");

    // Asynchronous reset between edges in RUN.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out_n", rst_out_n, 0);
    chk("async_ready", ready, 0);
    chk("async_loss", lock_loss_count, 0);
    chk("async_tmo", timeout_count, 0);
    chk("async_state", state, 0);
    do_reset();

    // Random lock and software-request traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      sw_reset_req = ($urandom_range(0, 15) == 0);
      cycle();
    end
    sw_reset_req = 1'b0;

    // Watchdog behaviour with lock held low.
    do_reset();
    if (WD) begin
      n = 0;
      do begin cycle(); n++; end while (pll_resetb && n < 100);
      chk("wd_first_pulse", n, NT);
      n = 0;
      do begin cycle(); n++; end while (!pll_resetb && n < 100);
      chk("wd_pulse_len", n, NP);
      n = 0;
      do begin cycle(); n++; end while (pll_resetb && n < 100);
      chk("wd_period", n, NT);
      chk("wd_tmo_count", timeout_count, 2);
    end else begin
      repeat (100) cycle();
      chk("nowd_pllb", pll_resetb, 1);
      chk("nowd_tmo", timeout_count, 0);
    end

    // Drive the loss counter into saturation.
    relock("pre_sat_run");
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      repeat (3) cycle();
      locked = 1'b1;
      n = 0;
      do begin cycle(); n++; end while (state != 2'd3 && n < 60);
    end
    chk("loss_saturated", lock_loss_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
